// File: rtl/axi_test_sched_pkg.sv
// axi_test_pkg: shared definitions for the AXI test-memory handshake scheduler.
//   - Channel indices (AW, W, B, AR, R) and channel count
//   - Per-channel FSM state encoding
//   - Offsets of the fast/async/delay/count fields inside the PRNG state
//   - xorshift64_step(): one step of the 64-bit xorshift generator
package axi_test_pkg;

  localparam int NUM_CH = 5;
  localparam int CH_AW  = 0;
  localparam int CH_W   = 1;
  localparam int CH_B   = 2;
  localparam int CH_AR  = 3;
  localparam int CH_R   = 4;

  localparam int FAST_OFS  = 0;
  localparam int ASYNC_OFS = 5;
  localparam int DELAY_OFS = 10;
  localparam int CNT_OFS   = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GRANT,
    PREGRANT
  } chan_state_t;

  function automatic logic [63:0] xorshift64_step(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

endpackage

// File: rtl/axi_test_sched_if.sv
// axi_test_sched_if: per-channel handshake bundle between the memory model
// side that has transactions pending and the timing scheduler.
//   req   : pending transaction per channel (the other side's valid)
//   grant : registered permission to complete the handshake
//   done  : req & grant, a handshake completes this cycle
// Modports: master drives req; slave (the scheduler) drives grant/done.
interface axi_test_sched_if;
  import axi_test_pkg::*;

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] done;

  modport master (output req, input grant, input done);
  modport slave  (input req, output grant, output done);

endinterface

// File: rtl/axi_test_sched_chan.sv
// axi_test_chan: one channel's handshake timing FSM plus its delay counter.
// Ports:
//   clk, resetn      : clock, synchronous active-low reset
//   req              : transaction pending on this channel
//   axi_test         : randomized timing enabled
//   fast/async/delay : random decision bits for this channel
//   count            : random delay length used when delay is set
//   grant            : registered permission to handshake
module axi_test_chan
  import axi_test_pkg::*;
#(
  parameter int DELAY_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req,
  input  logic               axi_test,
  input  logic               fast,
  input  logic               async,
  input  logic               delay,
  input  logic [DELAY_W-1:0] count,
  output logic               grant
);

  chan_state_t        state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic               grant_q;

  // State, counter and grant registers. grant is taken from the next state
  // so it is a plain flop with no combinational path from req.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= (state_d == GRANT) || (state_d == PREGRANT);
    end
  end

  // Next-state logic. In IDLE a pending req always wins over async.
  // GRANT/PREGRANT leave as soon as req is seen, because grant is already
  // high in that state and req & grant is the completed handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!axi_test || fast) begin
            state_d = GRANT;
          end else begin
            state_d = WAIT;
            cnt_d   = delay ? count : '0;
          end
        end else if (axi_test && async) begin
          state_d = PREGRANT;
        end
      end
      WAIT: begin
        // Dropping req is illegal on AXI; recover to IDLE without a grant.
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = GRANT;
        end else begin
          cnt_d = cnt_q - DELAY_W'(1);
        end
      end
      GRANT, PREGRANT: begin
        if (req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grant = grant_q;

endmodule

// File: rtl/axi_test_sched.sv
// axi_test_sched: per-channel handshake scheduler for the AXI test memory.
// Holds the 64-bit xorshift state and slices fast/async/delay/count bits
// for each of the five channels (AW, W, B, AR, R).
// Ports:
//   clk, resetn    : clock, synchronous active-low reset
//   axi_test       : enables randomized timing and PRNG stepping
//   bus            : req in, grant/done out (axi_test_sched_if.slave)
//   xorshift_state : current PRNG register
module axi_test_sched
  import axi_test_pkg::*;
#(
  parameter logic [63:0] SEED    = 64'h0000_0000_0000_0001,
  parameter int          DELAY_W = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   axi_test,
  axi_test_sched_if.slave        bus,
  output logic [63:0]            xorshift_state
);

  // An all-zero state is a fixed point of xorshift, so it is never loaded.
  localparam logic [63:0] SEED_INIT = (SEED == 64'h0) ? 64'h1 : SEED;

  logic [63:0]       x_q;
  logic [NUM_CH-1:0] grant;

  // PRNG register; channels see the value from before this cycle's step.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_q <= SEED_INIT;
    end else if (axi_test) begin
      x_q <= xorshift64_step(x_q);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    axi_test_chan #(
      .DELAY_W (DELAY_W)
    ) u_chan (
      .clk      (clk),
      .resetn   (resetn),
      .req      (bus.req[i]),
      .axi_test (axi_test),
      .fast     (x_q[FAST_OFS + i]),
      .async    (x_q[ASYNC_OFS + i]),
      .delay    (x_q[DELAY_OFS + i]),
      .count    (x_q[CNT_OFS + DELAY_W*i +: DELAY_W]),
      .grant    (grant[i])
    );
  end

  assign bus.grant      = grant;
  assign bus.done       = bus.req & grant;
  assign xorshift_state = x_q;

endmodule

// File: tb/tb_axi_test_sched.sv
// tb_axi_test_sched: scoreboard bench for axi_test_sched.
// Five DUT copies with different seeds share clk/resetn; each has its own
// interface, axi_test and req. Stimulus pushes time-stamped expectations
// (edge number, DUT, signal, value) into a queue; a monitor on the falling
// edge pops every entry due before the next rising edge and compares.
module tb_axi_test_sched;

  localparam int NDUT    = 5;
  localparam int K_GRANT = 0;
  localparam int K_DONE  = 1;
  localparam int K_STATE = 2;

  localparam logic [63:0] SEEDS [NDUT] = '{
    64'h1, 64'h1F, 64'h0000_0000_0500_1000, 64'h3E0, 64'h0
  };
  localparam logic [63:0] RESET_STATE [NDUT] = '{
    64'h1, 64'h1F, 64'h0000_0000_0500_1000, 64'h3E0, 64'h1
  };

  typedef struct {
    int          edge_no;
    int          dut;
    int          kind;
    logic [63:0] val;
    logic [4:0]  mask;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        axi_test_a [NDUT];
  logic [4:0]  req_a      [NDUT];
  wire  [4:0]  grant_a    [NDUT];
  wire  [4:0]  done_a     [NDUT];
  wire  [63:0] state_a    [NDUT];

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Rising-edge counter; after edge N settles, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar i = 0; i < NDUT; i++) begin : g_dut
    axi_test_sched_if bus ();

    assign bus.req    = req_a[i];
    assign grant_a[i] = bus.grant;
    assign done_a[i]  = bus.done;

    axi_test_sched #(
      .SEED    (SEEDS[i]),
      .DELAY_W (4)
    ) u_dut (
      .clk            (clk),
      .resetn         (resetn),
      .axi_test       (axi_test_a[i]),
      .bus            (bus.slave),
      .xorshift_state (state_a[i])
    );
  end

  // Independent reference: shifts written as explicit concatenations.
  function automatic logic [63:0] ref_step(input logic [63:0] v);
    logic [63:0] a;
    a = v ^ {v[50:0], 13'b0};
    a = a ^ {7'b0, a[63:7]};
    a = a ^ {a[46:0], 17'b0};
    return a;
  endfunction

  task automatic push_exp(input int e, input int dut, input int kind,
                          input logic [63:0] val, input logic [4:0] mask,
                          input string name);
    exp_t x;
    x.edge_no = e;
    x.dut     = dut;
    x.kind    = kind;
    x.val     = val;
    x.mask    = mask;
    x.name    = name;
    sb.push_back(x);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one DUT's inputs; t is the rising edge that will sample them.
  task automatic applyStimulus(input int dut, input logic at,
                               input logic [4:0] rq, output int t);
    axi_test_a[dut] = at;
    req_a[dut]      = rq;
    t               = cyc + 1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [63:0] got;
    logic [63:0] want;
    case (e.kind)
      K_GRANT: begin
        got  = {59'b0, grant_a[e.dut] & e.mask};
        want = {59'b0, e.val[4:0] & e.mask};
      end
      K_DONE: begin
        got  = {59'b0, done_a[e.dut] & e.mask};
        want = {59'b0, e.val[4:0] & e.mask};
      end
      default: begin
        got  = state_a[e.dut];
        want = e.val;
      end
    endcase
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("[TB] FAIL %s dut%0d edge %0d: got %h expected %h",
               e.name, e.dut, e.edge_no, got, want);
    end
  endtask

  // Monitor: compare every expectation whose edge is the next rising edge.
  always @(negedge clk) begin
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].edge_no == cyc + 1) begin
        checkOutput(sb[k]);
        sb.delete(k);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          t;
    logic [63:0] s;

    resetn = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      axi_test_a[i] = 1'b0;
      req_a[i]      = 5'b0;
    end

    // Reset state, sampled while resetn is still low.
    wait_edges(2);
    for (int i = 0; i < NDUT; i++) begin
      push_exp(cyc + 1, i, K_GRANT, 64'h0, 5'h1F, "reset_grant");
      push_exp(cyc + 1, i, K_DONE,  64'h0, 5'h1F, "reset_done");
      push_exp(cyc + 1, i, K_STATE, RESET_STATE[i], 5'h0, "reset_state");
    end
    wait_edges(1);
    resetn = 1'b1;
    wait_edges(2);

    // Bypass: axi_test=0, W channel granted one edge later.
    $display("[TB] bypass");
    applyStimulus(0, 1'b0, 5'b00010, t);
    push_exp(t + 1, 0, K_GRANT, 64'h02, 5'h1F, "bypass_grant");
    push_exp(t + 1, 0, K_DONE,  64'h02, 5'h1F, "bypass_done");
    push_exp(t + 2, 0, K_GRANT, 64'h00, 5'h1F, "bypass_grant_drop");
    push_exp(t + 2, 0, K_DONE,  64'h00, 5'h1F, "bypass_done_drop");
    push_exp(t + 3, 0, K_STATE, 64'h1,  5'h0,  "bypass_state_hold");
    wait_edges(2);
    req_a[0] = 5'b0;
    wait_edges(3);

    // Fast on every channel.
    $display("[TB] fast all");
    applyStimulus(1, 1'b1, 5'h1F, t);
    push_exp(t + 1, 1, K_GRANT, 64'h1F, 5'h1F, "fast_grant");
    push_exp(t + 1, 1, K_DONE,  64'h1F, 5'h1F, "fast_done");
    push_exp(t + 1, 1, K_STATE, ref_step(64'h1F), 5'h0, "fast_state1");
    push_exp(t + 2, 1, K_GRANT, 64'h00, 5'h1F, "fast_grant_drop");
    push_exp(t + 2, 1, K_STATE, ref_step(ref_step(64'h1F)), 5'h0, "fast_state2");
    wait_edges(2);
    req_a[1]      = 5'b0;
    axi_test_a[1] = 1'b0;
    wait_edges(3);

    // Delay of 5 on channel B; axi_test dropped while waiting.
    $display("[TB] delay");
    applyStimulus(2, 1'b1, 5'b00100, t);
    for (int k = 1; k <= 6; k++)
      push_exp(t + k, 2, K_GRANT, 64'h0, 5'h1F, "delay_grant_low");
    push_exp(t + 7, 2, K_GRANT, 64'h04, 5'h1F, "delay_grant_high");
    push_exp(t + 7, 2, K_DONE,  64'h04, 5'h1F, "delay_done");
    push_exp(t + 7, 2, K_STATE, ref_step(64'h0500_1000), 5'h0, "delay_state");
    push_exp(t + 8, 2, K_GRANT, 64'h0, 5'h1F, "delay_grant_drop");
    wait_edges(1);
    axi_test_a[2] = 1'b0;
    wait_edges(7);
    req_a[2] = 5'b0;
    wait_edges(3);

    // Async pre-grant on every channel, then an R handshake.
    $display("[TB] async pregrant");
    applyStimulus(3, 1'b1, 5'b0, t);
    push_exp(t + 1, 3, K_GRANT, 64'h1F, 5'h1F, "async_grant1");
    push_exp(t + 1, 3, K_DONE,  64'h00, 5'h1F, "async_done_idle");
    push_exp(t + 2, 3, K_GRANT, 64'h1F, 5'h1F, "async_grant2");
    push_exp(t + 3, 3, K_GRANT, 64'h1F, 5'h1F, "async_grant3");
    push_exp(t + 3, 3, K_DONE,  64'h10, 5'h1F, "async_done_r");
    push_exp(t + 4, 3, K_GRANT, 64'h0F, 5'h1F, "async_grant_r_drop");
    push_exp(t + 4, 3, K_STATE, ref_step(64'h3E0), 5'h0, "async_state");
    wait_edges(1);
    axi_test_a[3] = 1'b0;
    wait_edges(2);
    req_a[3] = 5'h10;
    wait_edges(1);
    req_a[3] = 5'b0;
    wait_edges(3);

    // Reset in the middle of a delay wait; no grant may survive it.
    $display("[TB] reset mid-wait");
    resetn = 1'b0;
    wait_edges(1);
    resetn = 1'b1;
    applyStimulus(2, 1'b1, 5'b00100, t);
    for (int k = 1; k <= 10; k++)
      push_exp(t + k, 2, K_GRANT, 64'h0, 5'h1F, "rst_wait_grant");
    push_exp(t + 3,  2, K_STATE, ref_step(64'h0500_1000), 5'h0, "rst_wait_state_pre");
    push_exp(t + 4,  2, K_STATE, 64'h0500_1000, 5'h0, "rst_wait_state_seed");
    push_exp(t + 10, 2, K_STATE, 64'h0500_1000, 5'h0, "rst_wait_state_hold");
    wait_edges(1);
    axi_test_a[2] = 1'b0;
    wait_edges(2);
    resetn = 1'b0;
    wait_edges(1);
    resetn   = 1'b1;
    req_a[2] = 5'b0;
    wait_edges(9);

    // PRNG: one step from 1, then 1000 more against the reference.
    $display("[TB] prng");
    applyStimulus(0, 1'b1, 5'b0, t);
    push_exp(t + 1, 0, K_STATE, 64'h0000_0000_4082_2041, 5'h0, "prng_step1");
    push_exp(t + 3, 0, K_STATE, 64'h0000_0000_4082_2041, 5'h0, "prng_hold");
    wait_edges(1);
    axi_test_a[0] = 1'b0;
    wait_edges(3);
    applyStimulus(0, 1'b1, 5'b0, t);
    s = 64'h0000_0000_4082_2041;
    for (int k = 1; k <= 1000; k++) begin
      s = ref_step(s);
      if (k % 100 == 0)
        push_exp(t + k, 0, K_STATE, s, 5'h0, "prng_run");
    end
    push_exp(t + 1005, 0, K_STATE, s, 5'h0, "prng_final_hold");
    wait_edges(1000);
    axi_test_a[0] = 1'b0;
    wait_edges(10);

    // Anything left in the scoreboard was never compared.
    while (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s dut%0d edge %0d: got no sample expected %h",
               sb[0].name, sb[0].dut, sb[0].edge_no, sb[0].val);
      void'(sb.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_test_sched.md
# axi_test_sched

Per-channel handshake scheduler for the AXI test memory model. Owns a 64-bit xorshift state and, for each of the five AXI channels (AW, W, B, AR, R), draws per-transaction fast, async and delay bits to decide when the memory side may assert its ready/valid. It replaces ad-hoc slicing of the random state in the memory model with a deterministic, seedable timing controller.

## Interface

**Parameters**
- `SEED`, default `64'h0000_0000_0000_0001`: initial xorshift state. The value 0 is replaced by 1.
- `DELAY_W`, default `4`: width of each per-channel delay count.

**Ports**
- `clk`, in, 1: the only clock.
- `resetn`, in, 1: reset. Synchronous, active-low.
- `axi_test`, in, 1: enables randomized timing and PRNG stepping.
- `req`, in, 5: per-channel pending transaction (the other side's valid). Bit 0=AW, 1=W, 2=B, 3=AR, 4=R.
- `grant`, out, 5: registered permission to complete the handshake on that channel.
- `done`, out, 5: combinational `req & grant`, meaning a handshake completes this cycle.
- `xorshift_state`, out, 64: current PRNG register, for debug and bench checking.

## Operation

**PRNG**
- Steps once per cycle while `axi_test=1`, otherwise holds.
- Step: `x ^= x<<13; x ^= x>>7; x ^= x<<17` (64-bit).
- Decisions in a cycle use the register value before that cycle's update.

**Bit map for channel i, from current x**
- fast = `x[i]`
- async = `x[5+i]`
- delay = `x[10+i]`
- count = `x[16+DELAY_W*i +: DELAY_W]`
- All channels may sample in the same cycle; their bit fields are disjoint.

**Per-channel FSM**
- **IDLE**
  - `req=1` and (`axi_test=0` or fast): go to GRANT.
  - `req=1`, delay, not fast: load count d, go to WAIT.
  - `req=1`, neither fast nor delay: load count 0, go to WAIT.
  - `req=0`, `axi_test=1`, async: go to PREGRANT.
  - Otherwise stay in IDLE.
  - When `req=1`, the req path has priority over async.
- **WAIT**
  - Counter is nonzero: decrement it.
  - Counter is 0: go to GRANT.
  - `req` drops: go to IDLE with no grant. This is defensive only, since AXI forbids dropping valid.
- **GRANT / PREGRANT**
  - `grant=1` and is held until `done`.
  - The cycle after `done`: go to IDLE with `grant=0`.
  - PREGRANT does not re-sample the random bits while held.
- Exactly one handshake per channel per GRANT/PREGRANT visit.
- Toggling `axi_test` mid-transaction does not affect a channel already in WAIT, GRANT or PREGRANT.

**Reset**
- Synchronous: takes effect on the `clk` edge while `resetn=0`, including mid-WAIT or mid-GRANT.
- Reset values: `grant=0`, all FSMs in IDLE, counters 0, `xorshift_state=SEED` (1 if `SEED=0`).
- `done` is 0 during reset because `grant` is 0.

## Timing

Let `req` first be sampled high at edge t while the channel is IDLE.
- `axi_test=0`, or fast: `grant` high at t+1.
- Delay with count d: `grant` high at t+2+d.
- Neither fast nor delay: `grant` high at t+2.
- PREGRANT: `grant` is already high, so `done` occurs in the same cycle `req` rises (zero latency).
- After `done` in cycle k: `grant` is low in cycle k+1. The earliest next grant for that channel is k+2.
- `done` has no register stage. `grant` is purely registered, with no combinational path from `req`.

## Structure

- **Package `axi_test_pkg`**
  - Channel index constants `CH_AW..CH_R` and `NUM_CH=5`.
  - Channel FSM state enum: IDLE, WAIT, GRANT, PREGRANT.
  - Function `xorshift64_step`.
  - Bit-map offset constants `FAST_OFS=0`, `ASYNC_OFS=5`, `DELAY_OFS=10`, `CNT_OFS=16`.
- **Sub-module `axi_test_chan`**
  - One FSM plus its `DELAY_W` counter.
  - Inputs: req, axi_test, fast, async, delay, count.
  - Output: grant.
  - Instantiated `NUM_CH` times in the top.
- **Top**
  - Holds the PRNG register and the bit slicing.

## Test plan

- **Bypass.** `axi_test=0`, `req=5'b00010` at t. Expect `grant[1]=1` at t+1 and `done[1]=1` in the same cycle. Then `grant[1]=0` at t+2, and `xorshift_state` stays at SEED throughout.
- **Fast all.** `SEED=64'h1F`, `axi_test` and `req=5'h1F` raised at t. Expect `grant=5'h1F` at t+1. Each bit then drops one cycle after its `done`.
- **Delay.** `SEED=64'h0000_0000_0500_1000` (ch2 delay bit set, count 5), `axi_test=1`, `req=5'b00100` at t. Expect `grant[2]` low through t+6 and high at t+7.
- **Async pre-grant.** `SEED=64'h3E0`, `axi_test=1` at t with `req=0`. Expect `grant=5'h1F` at t+1 and held there. `req[4]=1` at t+3 gives `done[4]=1` at t+3, then `grant[4]=0` at t+4.
- **Reset mid-WAIT.** Run the delay scenario, then drive `resetn=0` for one edge at t+3. Expect `grant=0` and `xorshift_state=SEED` on the next cycle, and no stale grant after `resetn` returns high.
- **PRNG.** `SEED=1`, `axi_test=1` for one edge. Expect `xorshift_state=64'h0000_0000_4082_2041`. After a further 1000 steps, the state matches the reference model and is never zero.
